// File: rtl/motor_ramp_seq.sv
// motor_ramp_seq: takes one move command at a time and drives the signed
// left/right wheel speeds. It ramps both wheels up to their targets, holds
// for a number of ticks, then ramps both back down to zero. e_stop forces
// the outputs to zero and returns the sequencer to IDLE.
module motor_ramp_seq #(
  parameter int STEP     = 8,
  parameter int TICK_DIV = 1024,
  parameter int DUR_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_vld,
  output logic                    cmd_rdy,
  input  logic signed [10:0]      tgt_lft,
  input  logic signed [10:0]      tgt_rht,
  input  logic        [DUR_W-1:0] dur,
  input  logic                    e_stop,
  output logic signed [10:0]      lft,
  output logic signed [10:0]      rht,
  output logic                    busy,
  output logic                    done
);

  localparam int                PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]     PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic signed [11:0] STEP_S    = 12'(STEP);
  localparam logic signed [10:0] SPEED_NEG = 11'sh400;  // -1024, not allowed
  localparam logic signed [10:0] SPEED_MIN = 11'sh401;  // -1023

  typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD, RAMP_DN} state_t;

  state_t                  state_q, state_d;
  logic signed [10:0]      lft_q, lft_d, rht_q, rht_d;
  logic signed [10:0]      tgt_lft_q, tgt_lft_d, tgt_rht_q, tgt_rht_d;
  logic        [DUR_W-1:0] dur_q, dur_d, hold_q, hold_d;
  logic        [PW-1:0]    presc_q, presc_d;
  logic                    done_q, done_d;
  logic                    tick;
  logic signed [10:0]      lft_step, rht_step;

  // Keep -1024 out of the datapath so the ramp stays symmetric.
  function automatic logic signed [10:0] clamp_tgt(input logic signed [10:0] t);
    return (t == SPEED_NEG) ? SPEED_MIN : t;
  endfunction

  // One ramp step from cur toward tgt; 12-bit difference cannot overflow
  // because both operands are limited to +/-1023.
  function automatic logic signed [10:0] step_to(input logic signed [10:0] cur,
                                                 input logic signed [10:0] tgt);
    logic signed [11:0] diff;
    logic signed [11:0] nxt;
    diff = {tgt[10], tgt} - {cur[10], cur};
    if ((diff <= STEP_S) && (diff >= -STEP_S)) begin
      nxt = {tgt[10], tgt};
    end else if (!diff[11]) begin
      nxt = {cur[10], cur} + STEP_S;
    end else begin
      nxt = {cur[10], cur} - STEP_S;
    end
    return nxt[10:0];
  endfunction

  assign tick    = (state_q != IDLE) && (presc_q == PRESC_MAX);
  assign cmd_rdy = (state_q == IDLE) && !e_stop;
  assign busy    = (state_q != IDLE);
  assign lft     = lft_q;
  assign rht     = rht_q;
  assign done    = done_q;

  // Next-state, speed, counter and done-pulse computation.
  always_comb begin
    state_d   = state_q;
    lft_d     = lft_q;
    rht_d     = rht_q;
    tgt_lft_d = tgt_lft_q;
    tgt_rht_d = tgt_rht_q;
    dur_d     = dur_q;
    hold_d    = hold_q;
    presc_d   = '0;
    done_d    = 1'b0;
    lft_step  = '0;
    rht_step  = '0;

    case (state_q)
      IDLE: begin
        if (cmd_vld && cmd_rdy) begin
          tgt_lft_d = clamp_tgt(tgt_lft);
          tgt_rht_d = clamp_tgt(tgt_rht);
          dur_d     = dur;
          state_d   = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (tick) begin
          lft_step = step_to(lft_q, tgt_lft_q);
          rht_step = step_to(rht_q, tgt_rht_q);
          lft_d    = lft_step;
          rht_d    = rht_step;
          if ((lft_step == tgt_lft_q) && (rht_step == tgt_rht_q)) begin
            state_d = HOLD;
            hold_d  = dur_q;
          end
        end
      end
      HOLD: begin
        // An expired count leaves on the very next clock, tick or not.
        if (hold_q == '0) begin
          state_d = RAMP_DN;
        end else if (tick) begin
          hold_d = hold_q - DUR_W'(1);
        end
      end
      RAMP_DN: begin
        if (tick) begin
          lft_step = step_to(lft_q, 11'sd0);
          rht_step = step_to(rht_q, 11'sd0);
          lft_d    = lft_step;
          rht_d    = rht_step;
          if ((lft_step == 11'sd0) && (rht_step == 11'sd0)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Prescaler restarts on every state change so each phase gets full ticks.
    if ((state_d == state_q) && (state_q != IDLE)) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    if (e_stop) begin
      state_d = IDLE;
      lft_d   = '0;
      rht_d   = '0;
      presc_d = '0;
      done_d  = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lft_q     <= '0;
      rht_q     <= '0;
      tgt_lft_q <= '0;
      tgt_rht_q <= '0;
      dur_q     <= '0;
      hold_q    <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lft_q     <= lft_d;
      rht_q     <= rht_d;
      tgt_lft_q <= tgt_lft_d;
      tgt_rht_q <= tgt_rht_d;
      dur_q     <= dur_d;
      hold_q    <= hold_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
    end
  end

endmodule
